// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolver.
//   pred_entry_t : one queued prediction {pc, hit, target}.
//   sNtaken..sTaken : 2-bit saturating direction counter encodings,
//                     matching the BTB's own counter states.
//   PC_STEP      : sequential fall-through increment.
package bp_pkg;

    // The queued target width is fixed here; the top-level TARGET_WIDTH
    // parameter must match it.
    localparam int BP_TARGET_WIDTH = 32;

    localparam logic [1:0] sNtaken = 2'b00;
    localparam logic [1:0] wNtaken = 2'b01;
    localparam logic [1:0] wTaken  = 2'b10;
    localparam logic [1:0] sTaken  = 2'b11;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0]                pc;
        logic                       hit;
        logic [BP_TARGET_WIDTH-1:0] target;
    } pred_entry_t;

endpackage

// File: rtl/pred_queue.sv
// Synchronous FIFO of pred_entry_t in program order.
// Ports:
//   clk, rst (sync active-low)
//   push/pushData : write an entry (ignored when full or flushing)
//   pop           : drop the head (ignored when empty)
//   flush         : clear the whole queue, pointers back to 0
//   headData      : oldest entry, combinational read
//   full, empty   : occupancy flags
module pred_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pred_entry_t pushData,
    input  logic        pop,
    input  logic        flush,
    output pred_entry_t headData,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);

    pred_entry_t    mem [DEPTH];
    logic [PW-1:0]  wrPtrReg;
    logic [PW-1:0]  rdPtrReg;
    logic [PW:0]    countReg;
    logic           doPush;
    logic           doPop;

    assign full     = (countReg == (PW+1)'(DEPTH));
    assign empty    = (countReg == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    // The head is needed in the same cycle the instruction resolves,
    // so the read is asynchronous (small distributed storage).
    assign headData = mem[rdPtrReg];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
            countReg <= countReg + (PW+1)'(doPush) - (PW+1)'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtrReg] <= pushData;
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-side consumer of BTB predictions. Queues each fetched
// instruction's prediction, checks it against the actual outcome when
// the instruction resolves, and drives the BTB update port plus a
// one-cycle front-end redirect on mispredict.
// Ports:
//   clk, rst (sync active-low)
//   fetchValid/fetchPc/fetchHit/fetchTarget, fetchReady : prediction in
//   exValid/exIsBranch/exTaken/exPc/exTarget            : resolution in
//   btbUpdate/btbTaken/btbPc/btbTarget                   : BTB update (registered)
//   redirectValid/redirectPc                             : redirect pulse (registered)
//   errSticky, branchCnt, mispredCnt                     : status / perf counters
module branch_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int TARGET_WIDTH = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetchValid,
    input  logic [31:0]             fetchPc,
    input  logic                    fetchHit,
    input  logic [TARGET_WIDTH-1:0] fetchTarget,
    output logic                    fetchReady,
    input  logic                    exValid,
    input  logic                    exIsBranch,
    input  logic                    exTaken,
    input  logic [31:0]             exPc,
    input  logic [TARGET_WIDTH-1:0] exTarget,
    output logic                    btbUpdate,
    output logic                    btbTaken,
    output logic [31:0]             btbPc,
    output logic [TARGET_WIDTH-1:0] btbTarget,
    output logic                    redirectValid,
    output logic [31:0]             redirectPc,
    output logic                    errSticky,
    output logic [CNT_WIDTH-1:0]    branchCnt,
    output logic [CNT_WIDTH-1:0]    mispredCnt
);

    pred_entry_t head;
    pred_entry_t fetchEntry;
    logic        queueFull;
    logic        queueEmpty;
    logic        resolveNow;
    logic        actualTaken;
    logic        mispredNow;
    logic        pushNow;
    logic [31:0] correctPc;
    logic        errNext;

    assign fetchEntry = '{pc: fetchPc, hit: fetchHit, target: fetchTarget};

    // Resolutions arriving while a redirect is in flight belong to the
    // wrong path and are dropped.
    assign resolveNow  = exValid && !queueEmpty && !redirectValid;
    assign actualTaken = exIsBranch && exTaken;
    assign mispredNow  = resolveNow &&
                         (( head.hit && !actualTaken) ||
                          (!head.hit &&  actualTaken) ||
                          ( head.hit &&  actualTaken && (head.target != exTarget)));

    // Readiness ignores a same-cycle pop so a full queue never takes a
    // new entry, and blocks fetch while the younger path is being flushed.
    assign fetchReady = !queueFull && !redirectValid && !mispredNow;
    assign pushNow    = fetchValid && fetchReady;

    assign correctPc = actualTaken ? 32'(exTarget) : (exPc + PC_STEP);

    assign errNext = errSticky ||
                     (exValid && queueEmpty && !redirectValid) ||
                     (resolveNow && (head.pc != exPc));

    pred_queue #(.DEPTH(DEPTH)) uQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (pushNow),
        .pushData (fetchEntry),
        .pop      (resolveNow),
        .flush    (mispredNow),
        .headData (head),
        .full     (queueFull),
        .empty    (queueEmpty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            btbUpdate     <= 1'b0;
            btbTaken      <= 1'b0;
            btbPc         <= '0;
            btbTarget     <= '0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            errSticky     <= 1'b0;
            branchCnt     <= '0;
            mispredCnt    <= '0;
        end else begin
            btbUpdate     <= resolveNow && (exIsBranch || head.hit);
            redirectValid <= mispredNow;
            errSticky     <= errNext;
            if (resolveNow) begin
                btbTaken  <= actualTaken;
                btbPc     <= exPc;
                btbTarget <= exTarget;
            end
            if (mispredNow) begin
                redirectPc <= correctPc;
                mispredCnt <= mispredCnt + 1'b1;
            end
            if (resolveNow && exIsBranch) branchCnt <= branchCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_branch_resolver;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fetchValid;
    logic [31:0] fetchPc;
    logic        fetchHit;
    logic [31:0] fetchTarget;
    logic        fetchReady;
    logic        exValid;
    logic        exIsBranch;
    logic        exTaken;
    logic [31:0] exPc;
    logic [31:0] exTarget;
    logic        btbUpdate;
    logic        btbTaken;
    logic [31:0] btbPc;
    logic [31:0] btbTarget;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        errSticky;
    logic [31:0] branchCnt;
    logic [31:0] mispredCnt;

    int total = 0;
    int bad   = 0;

    branch_resolver #(.DEPTH(DEPTH), .TARGET_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchHit(fetchHit),
        .fetchTarget(fetchTarget), .fetchReady(fetchReady),
        .exValid(exValid), .exIsBranch(exIsBranch), .exTaken(exTaken),
        .exPc(exPc), .exTarget(exTarget),
        .btbUpdate(btbUpdate), .btbTaken(btbTaken), .btbPc(btbPc),
        .btbTarget(btbTarget), .redirectValid(redirectValid),
        .redirectPc(redirectPc), .errSticky(errSticky),
        .branchCnt(branchCnt), .mispredCnt(mispredCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    bit          mValid = 0;
    logic        mBtbUpdate, mBtbTaken, mRedir, mErr;
    logic [31:0] mBtbPc, mBtbTarget, mRedirPc, mBranch, mMispred;

    // Inputs change just after the rising edge, so at the falling edge they
    // describe the coming edge: compare current state, then advance.
    always @(negedge clk) begin
        ent_t h;
        bit   res, at, mp, fr;
        if (mValid) begin
            check("btbUpdate",     btbUpdate,     mBtbUpdate);
            check("btbTaken",      btbTaken,      mBtbTaken);
            check("btbPc",         btbPc,         mBtbPc);
            check("btbTarget",     btbTarget,     mBtbTarget);
            check("redirectValid", redirectValid, mRedir);
            check("redirectPc",    redirectPc,    mRedirPc);
            check("errSticky",     errSticky,     mErr);
            check("branchCnt",     branchCnt,     mBranch);
            check("mispredCnt",    mispredCnt,    mMispred);
        end
        if (!rst) begin
            mq.delete();
            {mBtbUpdate, mBtbTaken, mRedir, mErr} = '0;
            {mBtbPc, mBtbTarget, mRedirPc, mBranch, mMispred} = '0;
            mValid = 1;
        end else if (mValid) begin
            res = exValid && (mq.size() > 0) && !mRedir;
            h   = res ? mq[0] : '{pc: 0, hit: 0, tgt: 0};
            at  = exIsBranch && exTaken;
            mp  = res && ((h.hit != at) || (h.hit && at && h.tgt != exTarget));
            fr  = (mq.size() < DEPTH) && !mRedir && !mp;
            check("fetchReady", fetchReady, fr);
            if (exValid && mq.size() == 0 && !mRedir) mErr = 1;
            mBtbUpdate = res && (exIsBranch || h.hit);
            mRedir     = mp;
            if (res) begin
                mBtbTaken  = at;
                mBtbPc     = exPc;
                mBtbTarget = exTarget;
                if (h.pc != exPc) mErr = 1;
                if (exIsBranch) mBranch = mBranch + 1;
                void'(mq.pop_front());
            end
            if (mp) begin
                mRedirPc = at ? exTarget : exPc + 32'd4;
                mMispred = mMispred + 1;
                mq.delete();
            end else if (fetchValid && fr) begin
                mq.push_back('{pc: fetchPc, hit: fetchHit, tgt: fetchTarget});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic setIdle();
        fetchValid = 0; fetchPc = 0; fetchHit = 0; fetchTarget = 0;
        exValid = 0; exIsBranch = 0; exTaken = 0; exPc = 0; exTarget = 0;
    endtask

    task automatic cyc(input logic fv, input logic [31:0] fpc, input logic fh,
                       input logic [31:0] ft, input logic ev, input logic eb,
                       input logic et, input logic [31:0] epc, input logic [31:0] etg);
        fetchValid = fv; fetchPc = fpc; fetchHit = fh; fetchTarget = ft;
        exValid = ev; exIsBranch = eb; exTaken = et; exPc = epc; exTarget = etg;
        @(posedge clk);
        #1;
        setIdle();
        #1;
        $display("t=%0t fv=%0b fpc=%h ev=%0b epc=%h -> upd=%0b redir=%0b rpc=%h err=%0b",
                 $time, fv, fpc, ev, epc, btbUpdate, redirectValid, redirectPc, errSticky);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        cyc(1, pc, hit, tgt, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
        cyc(0, 0, 0, 0, 1, br, tk, pc, tgt);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0;
        setIdle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("rst redirectValid", redirectValid, 0);
        check("rst branchCnt", branchCnt, 0);
        check("rst errSticky", errSticky, 0);
        check("rst fetchReady", fetchReady, 1);

        // correct taken
        fetch(32'h100, 1, 32'h200);
        resolve(1, 1, 32'h100, 32'h200);
        check("ok btbUpdate", btbUpdate, 1);
        check("ok btbTaken", btbTaken, 1);
        check("ok redirect", redirectValid, 0);
        check("ok mispredCnt", mispredCnt, 0);
        check("ok branchCnt", branchCnt, 1);

        // missed taken
        fetch(32'h104, 0, 0);
        resolve(1, 1, 32'h104, 32'h40);
        check("miss redirect", redirectValid, 1);
        check("miss redirectPc", redirectPc, 32'h40);
        check("miss fetchReady", fetchReady, 0);
        check("miss mispredCnt", mispredCnt, 1);
        idle();
        check("miss pulse end", redirectValid, 0);
        check("miss ready again", fetchReady, 1);

        // wrong target, then non-branch with a false hit
        fetch(32'h108, 1, 32'h300);
        resolve(1, 1, 32'h108, 32'h310);
        check("tgt redirectPc", redirectPc, 32'h310);
        idle();
        fetch(32'h10C, 1, 32'h500);
        resolve(0, 0, 32'h10C, 32'h0);
        check("nb redirectPc", redirectPc, 32'h110);
        check("nb btbUpdate", btbUpdate, 1);
        check("nb btbTaken", btbTaken, 0);
        check("nb branchCnt", branchCnt, 3);
        check("nb mispredCnt", mispredCnt, 3);
        idle();

        // flush with younger entries and a concurrent push
        fetch(32'h300, 0, 0);
        fetch(32'h304, 0, 0);
        fetch(32'h308, 0, 0);
        cyc(1, 32'h30C, 0, 0, 1, 1, 1, 32'h300, 32'h80);
        check("flush redirectPc", redirectPc, 32'h80);
        resolve(1, 0, 32'h304, 0);      // wrong-path, must be ignored
        check("flush ignored err", errSticky, 0);
        check("flush ignored cnt", branchCnt, 4);

        // full queue; a push concurrent with a pop is refused
        fetch(32'h200, 0, 0);
        fetch(32'h204, 0, 0);
        fetch(32'h208, 0, 0);
        fetch(32'h20C, 0, 0);
        check("full fetchReady", fetchReady, 0);
        cyc(1, 32'h210, 0, 0, 1, 1, 0, 32'h200, 0);
        check("full after pop", fetchReady, 1);
        resolve(1, 0, 32'h204, 0);
        resolve(1, 0, 32'h208, 0);
        resolve(1, 0, 32'h20C, 0);
        check("full drained cnt", branchCnt, 8);
        check("full no err yet", errSticky, 0);
        resolve(1, 0, 32'h210, 0);      // queue must be empty now
        check("underflow err", errSticky, 1);
        check("underflow cnt", branchCnt, 8);

        // reset at the mispredict edge cancels the redirect
        fetch(32'h400, 0, 0);
        rst = 0;
        resolve(1, 1, 32'h400, 32'h44);
        check("rstmid redirect", redirectValid, 0);
        check("rstmid mispredCnt", mispredCnt, 0);
        check("rstmid branchCnt", branchCnt, 0);
        check("rstmid err", errSticky, 0);
        rst = 1;
        idle();

        // fall-through pc wraps at 32 bits
        fetch(32'hFFFF_FFFC, 1, 32'h8);
        resolve(0, 0, 32'hFFFF_FFFC, 0);
        check("wrap redirect", redirectValid, 1);
        check("wrap redirectPc", redirectPc, 32'h0);
        check("wrap mispredCnt", mispredCnt, 1);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
